// File: rtl/timer_seq_pkg.sv
// Shared constants for the timer sequencer: FSM encodings, timer register map
// and control-word bit positions.
package timer_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_W_STOP = 3'd1;
  localparam state_t ST_W_PL   = 3'd2;
  localparam state_t ST_W_PH   = 3'd3;
  localparam state_t ST_W_CTRL = 3'd4;
  localparam state_t ST_RUN    = 3'd5;
  localparam state_t ST_W_CLR  = 3'd6;
  localparam state_t ST_W_HALT = 3'd7;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;

  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam logic [15:0] CTRL_STOP = 16'h0001 << CTRL_STOP_BIT;

  function automatic logic [15:0] ctrl_start(input logic cont);
    logic [15:0] v;
    v = '0;
    v[CTRL_ITO_BIT]   = 1'b1;
    v[CTRL_CONT_BIT]  = cont;
    v[CTRL_START_BIT] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/timer_seq_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [OWN_W-1:0]   grant_idx,
  output logic               valid
);

  int               idx;
  logic [OWN_W-1:0] idx_w;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = OWN_W'(idx);
      if (!valid && req[idx_w]) begin
        valid        = 1'b1;
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
      end
    end
  end

endmodule

// File: rtl/timer_seq_arbiter.sv
// Shares one interval timer among NUM_REQ requesters: round-robin grant,
// Avalon-MM programming of the timer, irq servicing and timeout reporting.
module timer_seq_arbiter
  import timer_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [32*NUM_REQ-1:0] req_period,
  input  logic [NUM_REQ-1:0]   req_cont,
  input  logic [NUM_REQ-1:0]   stop_req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic [OWN_W-1:0]     owner,
  output logic                 timeout_pulse,
  output logic [CNT_W-1:0]     timeout_count,
  input  logic                 timer_irq,
  output logic [2:0]           av_address,
  output logic                 av_chipselect,
  output logic                 av_write_n,
  output logic [15:0]          av_writedata
);

  state_t               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [OWN_W-1:0]     owner_q;
  logic [OWN_W-1:0]     ptr_q;
  logic [31:0]          period_q;
  logic                 cont_q;
  logic                 stop_pending_q;
  logic [CNT_W-1:0]     count_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [OWN_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [31:0]          pick_period;
  logic                 stop_now;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_comb begin
    pick_period = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == OWN_W'(i)) pick_period = req_period[32*i +: 32];
    end
  end

  // A stop pulse in the current cycle counts just like one already latched.
  assign stop_now = stop_pending_q | stop_req[owner_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      gnt_q          <= '0;
      owner_q        <= '0;
      ptr_q          <= '0;
      period_q       <= '0;
      cont_q         <= 1'b0;
      stop_pending_q <= 1'b0;
      count_q        <= '0;
    end else begin
      gnt_q <= '0;

      if (state_q == ST_IDLE)      stop_pending_q <= 1'b0;
      else if (stop_req[owner_q])  stop_pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q  <= ST_W_STOP;
            gnt_q    <= arb_grant;
            owner_q  <= arb_idx;
            period_q <= (pick_period == 32'd0) ? 32'd1 : pick_period;
            cont_q   <= req_cont[arb_idx];
            ptr_q    <= (arb_idx == OWN_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            count_q  <= '0;
          end
        end
        ST_W_STOP: state_q <= ST_W_PL;
        ST_W_PL:   state_q <= ST_W_PH;
        ST_W_PH:   state_q <= ST_W_CTRL;
        ST_W_CTRL: state_q <= ST_RUN;
        ST_RUN: begin
          if (timer_irq)     state_q <= ST_W_CLR;
          else if (stop_now) state_q <= ST_W_HALT;
        end
        ST_W_CLR: begin
          if (count_q != '1) count_q <= count_q + 1'b1;
          state_q <= (!cont_q || stop_now) ? ST_IDLE : ST_RUN;
        end
        ST_W_HALT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    av_chipselect = 1'b1;
    av_write_n    = 1'b0;
    av_address    = REG_STATUS;
    av_writedata  = '0;
    case (state_q)
      ST_W_STOP: begin
        av_address   = REG_CONTROL;
        av_writedata = CTRL_STOP;
      end
      ST_W_PL: begin
        av_address   = REG_PERIODL;
        av_writedata = period_q[15:0];
      end
      ST_W_PH: begin
        av_address   = REG_PERIODH;
        av_writedata = period_q[31:16];
      end
      ST_W_CTRL: begin
        av_address   = REG_CONTROL;
        av_writedata = ctrl_start(cont_q);
      end
      ST_W_CLR: begin
        av_address   = REG_STATUS;
        av_writedata = 16'h0000;
      end
      ST_W_HALT: begin
        av_address   = REG_CONTROL;
        av_writedata = CTRL_STOP;
      end
      default: begin
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
      end
    endcase
  end

  assign gnt           = gnt_q;
  assign busy          = (state_q != ST_IDLE);
  assign owner         = owner_q;
  assign timeout_pulse = (state_q == ST_W_CLR);
  assign timeout_count = count_q;

endmodule

// File: tb/tb_timer_seq_arbiter.sv
// Directed bench for timer_seq_arbiter; counter width reduced to 8 so the
// saturation scenario stays short.
module tb_timer_seq_arbiter;

  localparam int NR = 4;
  localparam int OW = 2;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [32*NR-1:0] req_period;
  logic [NR-1:0]   req_cont;
  logic [NR-1:0]   stop_req;
  logic [NR-1:0]   gnt;
  logic            busy;
  logic [OW-1:0]   owner;
  logic            timeout_pulse;
  logic [CW-1:0]   timeout_count;
  logic            timer_irq;
  logic [2:0]      av_address;
  logic            av_chipselect;
  logic            av_write_n;
  logic [15:0]     av_writedata;

  int checks   = 0;
  int failures = 0;

  timer_seq_arbiter #(.NUM_REQ(NR), .OWN_W(OW), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_period    (req_period),
    .req_cont      (req_cont),
    .stop_req      (stop_req),
    .gnt           (gnt),
    .busy          (busy),
    .owner         (owner),
    .timeout_pulse (timeout_pulse),
    .timeout_count (timeout_count),
    .timer_irq     (timer_irq),
    .av_address    (av_address),
    .av_chipselect (av_chipselect),
    .av_write_n    (av_write_n),
    .av_writedata  (av_writedata)
  );

  always #5 clk = ~clk;

  // {chipselect, write_n, address, writedata}
  logic [20:0] bus;
  assign bus = {av_chipselect, av_write_n, av_address, av_writedata};
  localparam logic [20:0] IDLE_BUS = {1'b0, 1'b1, 3'd0, 16'h0000};

  function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, 1'b0, a, d};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus !== IDLE_BUS) begin failures++; $display("FAIL reset_bus got=%h exp=%h", bus, IDLE_BUS); end
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
      failures++; $display("FAIL reset_ctl gnt=%b busy=%b owner=%0d exp 0000/0/0", gnt, busy, owner); end
    checks++; if (timeout_pulse !== 1'b0 || timeout_count !== 8'h00) begin
      failures++; $display("FAIL reset_cnt pulse=%b count=%h exp 0/00", timeout_pulse, timeout_count); end
    reset = 1'b0;
  endtask

  task automatic test_grant_cont();
    logic [20:0] exp [4];
    exp = '{wr(3'd1, 16'h0008), wr(3'd2, 16'h86A0), wr(3'd3, 16'h0001), wr(3'd1, 16'h0007)};
    req_period[2*32 +: 32] = 32'h0001_86A0;
    req_cont[2] = 1'b1;
    req[2] = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL cont_gnt got=%b exp=0100", gnt); end
    req[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (bus !== exp[k] || busy !== 1'b1) begin
        failures++; $display("FAIL cont_write%0d got=%h busy=%b exp=%h busy=1", k, bus, busy, exp[k]); end
    end
    @(negedge clk);
    checks++; if (bus !== IDLE_BUS || busy !== 1'b1 || owner !== 2'd2 || gnt !== 4'b0000) begin
      failures++; $display("FAIL cont_run bus=%h busy=%b owner=%0d gnt=%b", bus, busy, owner, gnt); end
  endtask

  task automatic test_irq_saturate();
    int pulses;
    timer_irq = 1'b1;
    @(negedge clk);
    checks++; if (bus !== wr(3'd0, 16'h0000) || timeout_pulse !== 1'b1) begin
      failures++; $display("FAIL irq_clr bus=%h pulse=%b exp %h/1", bus, timeout_pulse, wr(3'd0, 16'h0000)); end
    timer_irq = 1'b0;
    @(negedge clk);
    checks++; if (bus !== IDLE_BUS || timeout_pulse !== 1'b0 || timeout_count !== 8'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL irq_back_run bus=%h pulse=%b count=%h busy=%b", bus, timeout_pulse, timeout_count, busy); end
    pulses = 0;
    repeat (256) begin
      timer_irq = 1'b1;
      @(negedge clk);
      pulses += int'(timeout_pulse);
      timer_irq = 1'b0;
      @(negedge clk);
    end
    checks++; if (pulses != 256) begin failures++; $display("FAIL sat_pulses got=%0d exp=256", pulses); end
    checks++; if (timeout_count !== 8'hFF) begin failures++; $display("FAIL sat_count got=%h exp=ff", timeout_count); end
    stop_req[0] = 1'b1;
    @(negedge clk);
    stop_req[0] = 1'b0;
    @(negedge clk);
    checks++; if (bus !== IDLE_BUS || busy !== 1'b1) begin
      failures++; $display("FAIL nonowner_stop bus=%h busy=%b exp idle/1", bus, busy); end
    stop_req[2] = 1'b1;
    @(negedge clk);
    stop_req[2] = 1'b0;
    checks++; if (bus !== wr(3'd1, 16'h0008)) begin failures++; $display("FAIL owner_halt got=%h exp=%h", bus, wr(3'd1, 16'h0008)); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || owner !== 2'd2 || timeout_count !== 8'hFF || bus !== IDLE_BUS) begin
      failures++; $display("FAIL halt_idle busy=%b owner=%0d count=%h bus=%h", busy, owner, timeout_count, bus); end
  endtask

  task automatic test_oneshot();
    logic [20:0] exp [4];
    exp = '{wr(3'd1, 16'h0008), wr(3'd2, 16'h0010), wr(3'd3, 16'h0000), wr(3'd1, 16'h0005)};
    req_period[1*32 +: 32] = 32'h0000_0010;
    req_cont[1] = 1'b0;
    req[1] = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL os_gnt got=%b exp=0010", gnt); end
    req[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (bus !== exp[k]) begin failures++; $display("FAIL os_write%0d got=%h exp=%h", k, bus, exp[k]); end
    end
    @(negedge clk);
    checks++; if (timeout_count !== 8'h00 || owner !== 2'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL os_run count=%h owner=%0d busy=%b exp 00/1/1", timeout_count, owner, busy); end
    timer_irq = 1'b1;
    @(negedge clk);
    timer_irq = 1'b0;
    checks++; if (bus !== wr(3'd0, 16'h0000)) begin failures++; $display("FAIL os_clr got=%h", bus); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || timeout_count !== 8'd1 || bus !== IDLE_BUS) begin
      failures++; $display("FAIL os_done busy=%b count=%h bus=%h exp 0/01/idle", busy, timeout_count, bus); end
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    int seen;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NR; i++) req_period[i*32 +: 32] = 32'h0000_0020;
    req_cont = '0;
    reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      seen = -1;
      for (int w = 0; w < 8; w++) begin
        @(negedge clk);
        if (gnt != 4'b0000) begin
          case (gnt)
            4'b0001: seen = 0;
            4'b0010: seen = 1;
            4'b0100: seen = 2;
            4'b1000: seen = 3;
            default: seen = 99;
          endcase
          break;
        end
      end
      checks++; if (seen != exp_order[k]) begin failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", k, seen, exp_order[k]); end
      if (k == 4) req = '0;
      repeat (4) @(negedge clk);
      timer_irq = 1'b1;
      @(negedge clk);
      timer_irq = 1'b0;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_end busy=%b exp=0", busy); end
  endtask

  task automatic test_stop_irq();
    req_period[3*32 +: 32] = 32'h0000_0100;
    req_cont[3] = 1'b1;
    req[3] = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL si_gnt got=%b exp=1000", gnt); end
    req[3] = 1'b0;
    repeat (4) @(negedge clk);
    stop_req[1] = 1'b1;
    @(negedge clk);
    stop_req[1] = 1'b0;
    timer_irq = 1'b1;
    @(negedge clk);
    timer_irq = 1'b0;
    checks++; if (bus !== wr(3'd0, 16'h0000)) begin failures++; $display("FAIL si_clr1 got=%h", bus); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || bus !== IDLE_BUS || timeout_count !== 8'd1) begin
      failures++; $display("FAIL si_rerun busy=%b bus=%h count=%h exp 1/idle/01", busy, bus, timeout_count); end
    timer_irq = 1'b1;
    stop_req[3] = 1'b1;
    @(negedge clk);
    timer_irq = 1'b0;
    stop_req[3] = 1'b0;
    checks++; if (bus !== wr(3'd0, 16'h0000) || timeout_pulse !== 1'b1) begin
      failures++; $display("FAIL si_clr2 bus=%h pulse=%b", bus, timeout_pulse); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus !== IDLE_BUS || timeout_count !== 8'd2) begin
      failures++; $display("FAIL si_idle busy=%b bus=%h count=%h exp 0/idle/02", busy, bus, timeout_count); end
    @(negedge clk);
    checks++; if (bus !== IDLE_BUS) begin failures++; $display("FAIL si_no_halt got=%h", bus); end
  endtask

  task automatic test_reset_mid();
    logic [20:0] exp [4];
    exp = '{wr(3'd1, 16'h0008), wr(3'd2, 16'h0001), wr(3'd3, 16'h0000), wr(3'd1, 16'h0005)};
    req_period[0 +: 32] = 32'h1234_5678;
    req_cont[0] = 1'b0;
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    checks++; if (bus !== wr(3'd2, 16'h5678)) begin failures++; $display("FAIL rm_pl got=%h exp=%h", bus, wr(3'd2, 16'h5678)); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus !== IDLE_BUS || busy !== 1'b0) begin failures++; $display("FAIL rm_idle bus=%h busy=%b", bus, busy); end
    reset = 1'b0;
    req_period[0 +: 32] = 32'h0000_0000;
    req[0] = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rm_gnt got=%b exp=0001", gnt); end
    req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (bus !== exp[k]) begin failures++; $display("FAIL rm_write%0d got=%h exp=%h", k, bus, exp[k]); end
    end
    @(negedge clk);
    timer_irq = 1'b1;
    @(negedge clk);
    timer_irq = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_done busy=%b exp=0", busy); end
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    req_period = '0;
    req_cont   = '0;
    stop_req   = '0;
    timer_irq  = 1'b0;
    test_reset();
    test_grant_cont();
    test_irq_saturate();
    test_oneshot();
    test_round_robin();
    test_stop_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
